// File: rtl/npc_lsu_pkg.sv
// rtl/npc_lsu_pkg.sv - npc_lsu shared types: FSM states, funct3 size codes, size decode helpers
package npc_lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lsu_size_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unlisted funct3 encodings fall through to word access.
    function automatic lsu_size_e size_of(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (size_of(funct3))
            SZ_H:    return addr_lo[0];
            SZ_W:    return addr_lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// rtl/npc_lsu_align.sv - combinational store lane/mask generation and load extract/extend
module npc_lsu_align
    import npc_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wlanes,
    output logic [31:0] rdata_ext
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    logic        is_unsigned;

    always_comb begin
        byte_sh     = rdata >> {addr_lo, 3'b000};
        half_sh     = rdata >> {addr_lo[1], 4'b0000};
        is_unsigned = funct3[2];
        wmask       = 4'b1111;
        wlanes      = wdata;
        rdata_ext   = rdata;
        case (size_of(funct3))
            SZ_B: begin
                wmask     = 4'b0001 << addr_lo;
                wlanes    = {4{wdata[7:0]}};
                rdata_ext = is_unsigned ? {24'b0, byte_sh[7:0]}
                                        : {{24{byte_sh[7]}}, byte_sh[7:0]};
            end
            SZ_H: begin
                wmask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes    = {2{wdata[15:0]}};
                rdata_ext = is_unsigned ? {16'b0, half_sh[15:0]}
                                        : {{16{half_sh[15]}}, half_sh[15:0]};
            end
            default: begin
                wmask     = 4'b1111;
                wlanes    = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// rtl/npc_lsu.sv - single-outstanding load/store unit; LSU_MISALIGN_CHECK_EN enables misaligned-access error responses
module npc_lsu
    import npc_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_wen,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    lsu_state_e  state_q, state_d;
    logic        wen_q, wen_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] cnt_q, cnt_d;

    logic [3:0]  wmask_w;
    logic [31:0] wlanes_w;
    logic [31:0] rext_w;
    logic        timeout_hit;
    logic        busy_q, busy_d;

    npc_lsu_align u_align (
        .funct3    (f3_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wmask     (wmask_w),
        .wlanes    (wlanes_w),
        .rdata_ext (rext_w)
    );

    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        busy_q      = (state_q == REQ) || (state_q == WAIT);
        timeout_hit = (TIMEOUT_CYC != 0) && busy_q && (cnt_q == 32'(TIMEOUT_CYC - 1));

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wen_d   = req_wen;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = REQ;
`ifdef LSU_MISALIGN_CHECK_EN
                    if (is_misaligned(req_funct3, req_addr[1:0])) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
`endif
                end
            end
            REQ: begin
                if (timeout_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (mem_ready) begin
                    state_d = wen_q ? RESP : WAIT;
                end
            end
            WAIT: begin
                // A timeout wins over a same-cycle rvalid so the response is always an error once the budget is spent.
                if (timeout_hit) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else if (mem_rvalid) begin
                    rdata_d = rext_w;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == REQ) || (state_d == WAIT);
        cnt_d  = (busy_q && busy_d) ? cnt_q + 32'd1 : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign mem_valid  = (state_q == REQ);
    assign mem_wen    = (state_q == REQ) && wen_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wdata  = wlanes_w;
    assign mem_wmask  = ((state_q == REQ) && wen_q) ? wmask_w : 4'b0000;
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP) ? rdata_q : 32'b0;

endmodule

// File: tb/tb_npc_lsu.sv
// tb/tb_npc_lsu.sv - directed self-checking bench for npc_lsu (TIMEOUT_CYC=8)
module tb_npc_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_valid, mem_ready, mem_wen, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc;
    int          pulses;
    logic        saw_mv;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_wmask;
    logic        cap_wen;

    npc_lsu #(.TIMEOUT_CYC(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wmask  (mem_wmask),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issues one request, then runs until resp_valid (bounded); captures the first REQ-cycle memory outputs.
    task automatic run_req(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata, input logic rv);
        req_valid  = 1'b1;
        req_wen    = wen;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        mem_ready  = 1'b1;
        mem_rvalid = rv;
        mem_rdata  = rdata;
        tick;
        req_valid = 1'b0;
        cyc       = 1;
        saw_mv    = mem_valid;
        cap_addr  = mem_addr;
        cap_wdata = mem_wdata;
        cap_wmask = mem_wmask;
        cap_wen   = mem_wen;
        while (!resp_valid && cyc < 20) begin
            tick;
            cyc++;
            saw_mv = saw_mv | mem_valid;
        end
    endtask

    task automatic count_pulses(input int n);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            pulses += int'(resp_valid);
            tick;
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_funct3 = 3'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        tick;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd0);
        chk("rst_mem_wmask", 32'(mem_wmask), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        tick;
        rst = 1'b0;
        tick;

        run_req(1'b0, 3'b010, 32'h8000_0100, 32'h0, 32'hDEAD_BEEF, 1'b1);
        chk("lw_latency", 32'(cyc), 32'd3);
        chk("lw_addr", cap_addr, 32'h8000_0100);
        chk("lw_wmask", 32'(cap_wmask), 32'd0);
        chk("lw_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("lw_err", 32'(resp_err), 32'd0);
        tick;
        chk("lw_back_idle_ready", 32'(req_ready), 32'd1);
        chk("lw_pulse_once", 32'(resp_valid), 32'd0);

        run_req(1'b0, 3'b000, 32'h8000_0103, 32'h0, 32'h80FF_7F01, 1'b1);
        chk("lb_b3", resp_rdata, 32'hFFFF_FF80);
        tick;
        run_req(1'b0, 3'b100, 32'h8000_0103, 32'h0, 32'h80FF_7F01, 1'b1);
        chk("lbu_b3", resp_rdata, 32'h0000_0080);
        tick;
        run_req(1'b0, 3'b101, 32'h8000_0102, 32'h0, 32'h80FF_7F01, 1'b1);
        chk("lhu_h1", resp_rdata, 32'h0000_80FF);
        tick;
        run_req(1'b0, 3'b001, 32'h8000_0102, 32'h0, 32'h80FF_7F01, 1'b1);
        chk("lh_h1", resp_rdata, 32'hFFFF_80FF);
        tick;
        run_req(1'b0, 3'b000, 32'h8000_0101, 32'h0, 32'h80FF_7F01, 1'b1);
        chk("lb_b1", resp_rdata, 32'h0000_007F);
        tick;
        run_req(1'b0, 3'b101, 32'h8000_0100, 32'h0, 32'h80FF_8F01, 1'b1);
        chk("lhu_h0", resp_rdata, 32'h0000_8F01);
        tick;
        run_req(1'b0, 3'b111, 32'h8000_0104, 32'h0, 32'h8123_4567, 1'b1);
        chk("f3_111_as_w", resp_rdata, 32'h8123_4567);
        tick;

        run_req(1'b1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 32'hFFFF_FFFF, 1'b1);
        chk("sb_latency", 32'(cyc), 32'd2);
        chk("sb_wen", 32'(cap_wen), 32'd1);
        chk("sb_wmask", 32'(cap_wmask), 32'b0010);
        chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
        chk("sb_addr", cap_addr, 32'h8000_0000);
        chk("sb_rdata_zero", resp_rdata, 32'h0);
        tick;
        run_req(1'b1, 3'b001, 32'h8000_0002, 32'h1234_BEEF, 32'h0, 1'b1);
        chk("sh_wmask", 32'(cap_wmask), 32'b1100);
        chk("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
        tick;
        run_req(1'b1, 3'b010, 32'h8000_0004, 32'hCAFE_F00D, 32'h0, 1'b1);
        chk("sw_wmask", 32'(cap_wmask), 32'b1111);
        chk("sw_wdata", cap_wdata, 32'hCAFE_F00D);
        tick;

        mem_ready = 1'b0; mem_rvalid = 1'b0;
        req_valid = 1'b1; req_wen = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h8000_0010; req_wdata = 32'h0102_0304;
        tick;
        req_valid = 1'b0;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            chk("stall_mem_valid", 32'(mem_valid), 32'd1);
            chk("stall_addr", mem_addr, 32'h8000_0010);
            chk("stall_wdata", mem_wdata, 32'h0102_0304);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            pulses += int'(resp_valid);
            tick;
        end
        mem_ready = 1'b1;
        tick;
        chk("stall_resp", 32'(resp_valid), 32'd1);
        count_pulses(4);
        chk("stall_pulses", 32'(pulses), 32'd1);

        run_req(1'b0, 3'b010, 32'h8000_0200, 32'h0, 32'h5555_5555, 1'b0);
        chk("to_latency", 32'(cyc), 32'd9);
        chk("to_err", 32'(resp_err), 32'd1);
        chk("to_rdata", resp_rdata, 32'h0);
        chk("to_mem_valid", 32'(mem_valid), 32'd0);
        mem_rvalid = 1'b1;
        tick;
        count_pulses(4);
        chk("to_late_rvalid", 32'(pulses), 32'd0);

        mem_ready = 1'b0;
        req_valid = 1'b1; req_wen = 1'b0; req_funct3 = 3'b010; req_addr = 32'h8000_0300;
        tick;
        req_valid = 1'b0;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midrst_ready", 32'(req_ready), 32'd1);
        chk("midrst_mem_valid", 32'(mem_valid), 32'd0);
        mem_ready = 1'b1;
        count_pulses(4);
        chk("midrst_no_resp", 32'(pulses), 32'd0);

        run_req(1'b0, 3'b010, 32'h8000_0102, 32'h0, 32'h1122_3344, 1'b1);
`ifdef LSU_MISALIGN_CHECK_EN
        chk("mis_latency", 32'(cyc), 32'd1);
        chk("mis_err", 32'(resp_err), 32'd1);
        chk("mis_rdata", resp_rdata, 32'h0);
        chk("mis_no_mem", 32'(saw_mv), 32'd0);
`else
        chk("mis_latency", 32'(cyc), 32'd3);
        chk("mis_err", 32'(resp_err), 32'd0);
        chk("mis_rdata", resp_rdata, 32'h1122_3344);
        chk("mis_addr", cap_addr, 32'h8000_0100);
`endif
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
